// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode values, AluOp encodings and the decoded control-word type shared by the pipeline control block.
package ctrl_pkg;
   localparam int unsigned OP_RTYPE = 0;
   localparam int unsigned OP_J     = 2;
   localparam int unsigned OP_BEQ   = 4;
   localparam int unsigned OP_BNE   = 5;
   localparam int unsigned OP_ADDI  = 8;
   localparam int unsigned OP_SLTI  = 10;
   localparam int unsigned OP_ANDI  = 12;
   localparam int unsigned OP_ORI   = 13;
   localparam int unsigned OP_LW    = 35;
   localparam int unsigned OP_SW    = 43;

   localparam logic [2:0] ALU_ADD     = 3'b000;
   localparam logic [2:0] ALU_SUB     = 3'b001;
   localparam logic [2:0] ALU_R_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND     = 3'b011;
   localparam logic [2:0] ALU_OR      = 3'b100;
   localparam logic [2:0] ALU_SLT     = 3'b101;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       bne;
      logic       reg_write;
      logic       mem_to_reg;
      logic       jump;
   } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode-to-control decode; unknown opcodes yield an all-zero word with illegal set.
module ctrl_decode import ctrl_pkg::*; #(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op_code,
   output ctrl_t           ctrl,
   output logic            illegal
);
   always_comb begin
      ctrl = '0;
      illegal = 1'b0;
      case (op_code)
         OP_W'(OP_RTYPE): begin ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_R_FUNCT; ctrl.reg_write = 1'b1; end
         OP_W'(OP_J):     ctrl.jump = 1'b1;
         OP_W'(OP_BEQ):   begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
         OP_W'(OP_BNE):   begin ctrl.branch = 1'b1; ctrl.bne = 1'b1; ctrl.alu_op = ALU_SUB; end
         OP_W'(OP_ADDI):  begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; end
         OP_W'(OP_SLTI):  begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLT; ctrl.reg_write = 1'b1; end
         OP_W'(OP_ANDI):  begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_AND; ctrl.reg_write = 1'b1; end
         OP_W'(OP_ORI):   begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR; ctrl.reg_write = 1'b1; end
         OP_W'(OP_LW):    begin ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
         OP_W'(OP_SW):    begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
         default:         illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: pipelined MIPS control with ID/EX, EX/MEM, MEM/WB registers, load-use stall and branch/jump flush.
// Define STALL_COUNT_EN to add a saturating stall_count output.
module ctrl_pipeline import ctrl_pkg::*; #(
   parameter int OP_W    = 6,
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [OP_W-1:0]    id_op_code,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic               ex_branch_taken,
   output logic               stall,
   output logic               if_flush,
   output logic               id_jump,
   output logic               ex_reg_dst,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_branch,
   output logic               mem_bne,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic               illegal_op
`ifdef STALL_COUNT_EN
   ,
   output logic [CNT_W-1:0]   stall_count
`endif
);
   ctrl_t dec;
   logic dec_illegal, hazard, bubble;
   logic ex_mem_read, ex_mem_write, ex_branch, ex_bne, ex_reg_write, ex_mem_to_reg;
   logic mem_reg_write, mem_mem_to_reg;
   logic [REG_W-1:0] ex_rt;

   ctrl_decode #(.OP_W(OP_W)) u_decode (.op_code(id_op_code), .ctrl(dec), .illegal(dec_illegal));

   // A taken branch flushes ID, so it masks both the stall and the jump.
   always_comb begin
      hazard = id_valid && ex_mem_read && (ex_rt != '0) && (ex_rt == id_rs || ex_rt == id_rt);
      stall = hazard && !ex_branch_taken;
      id_jump = id_valid && dec.jump && !ex_branch_taken;
      if_flush = ex_branch_taken || id_jump;
      bubble = ex_branch_taken || hazard || !id_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {ex_reg_dst, ex_alu_src, ex_alu_op, illegal_op, ex_rt} <= '0;
         {ex_mem_read, ex_mem_write, ex_branch, ex_bne, ex_reg_write, ex_mem_to_reg} <= '0;
         {mem_read, mem_write, mem_branch, mem_bne, mem_reg_write, mem_mem_to_reg} <= '0;
         {wb_reg_write, wb_mem_to_reg} <= '0;
      end else begin
         ex_reg_dst <= !bubble && dec.reg_dst;
         ex_alu_src <= !bubble && dec.alu_src;
         ex_alu_op <= bubble ? '0 : ALUOP_W'(dec.alu_op);
         illegal_op <= !bubble && dec_illegal;
         ex_rt <= id_rt;
         ex_mem_read <= !bubble && dec.mem_read;
         ex_mem_write <= !bubble && dec.mem_write;
         ex_branch <= !bubble && dec.branch;
         ex_bne <= !bubble && dec.bne;
         ex_reg_write <= !bubble && dec.reg_write;
         ex_mem_to_reg <= !bubble && dec.mem_to_reg;
         {mem_read, mem_write, mem_branch, mem_bne, mem_reg_write, mem_mem_to_reg} <=
            {ex_mem_read, ex_mem_write, ex_branch, ex_bne, ex_reg_write, ex_mem_to_reg};
         {wb_reg_write, wb_mem_to_reg} <= {mem_reg_write, mem_mem_to_reg};
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_count <= '0;
      else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
   end
`endif
endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Parametrised successor to the single-cycle main control decoder for the pipelined MIPS core.
- Decodes the ID-stage opcode, including immediate ops and bne.
- Carries control bits through registered ID/EX, EX/MEM and MEM/WB stages.
- Detects load-use hazards (stall plus bubble) and applies branch/jump flushes, so downstream stages read their control fields directly from this block.

Parameters:
- OP_W, 6, opcode width.
- REG_W, 5, register-address width.
- ALUOP_W, 3, ALU-op field width; minimum 3.
- CNT_W, 16, stall-counter width; used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_op_code  in  OP_W  instruction[31:26].
- id_rs  in  REG_W  instruction[25:21].
- id_rt  in  REG_W  instruction[20:16].
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- stall  out  1  combinational; hold PC and IF/ID.
- if_flush  out  1  combinational; zero the IF/ID instruction.
- id_jump  out  1  combinational; ID holds a valid j.
- ex_reg_dst, ex_alu_src  out  1 each  ID/EX register.
- ex_alu_op  out  ALUOP_W  ID/EX register.
- mem_read, mem_write, mem_branch, mem_bne  out  1 each  EX/MEM register.
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB register.
- illegal_op  out  1  ID/EX register; unknown opcode reached EX.
- stall_count  out  CNT_W  present only with STALL_COUNT_EN.

Behaviour:
- Reset: every registered output and the internal ex_rt/ex_mem_read are 0 immediately; all outputs stay 0 until the first decoded instruction advances.
- Decode is combinational on id_op_code. Fields: RegDst, AluSrc, AluOp, MemRead, MemWrite, Branch, Bne, RegWrite, MemtoReg, Jump.
  - 0 R: RegDst=1, AluOp=R_FUNCT, RegWrite=1.
  - 2 j: Jump=1, all other fields 0.
  - 4 beq: Branch=1, AluOp=SUB.
  - 5 bne: Branch=1, Bne=1, AluOp=SUB.
  - 8 addi: AluSrc=1, AluOp=ADD, RegWrite=1.
  - 10 slti: AluSrc=1, AluOp=SLT, RegWrite=1.
  - 12 andi: AluSrc=1, AluOp=AND, RegWrite=1.
  - 13 ori: AluSrc=1, AluOp=OR, RegWrite=1.
  - 35 lw: AluSrc=1, AluOp=ADD, MemRead=1, RegWrite=1, MemtoReg=1.
  - 43 sw: AluSrc=1, AluOp=ADD, MemWrite=1.
  - Any other opcode: all fields 0, illegal=1. Don't-care bits are always driven 0.
- AluOp encodings: ADD=000, SUB=001, R_FUNCT=010, AND=011, OR=100, SLT=101. Upper bits are 0 when ALUOP_W>3.
- Latency:
  - EX fields 1 cycle after ID.
  - MEM fields 2 cycles after ID.
  - WB fields 3 cycles after ID.
  - EX/MEM and MEM/WB always advance, with no hold.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid is 1;
  - ex_mem_read is 1;
  - ex_rt is nonzero;
  - ex_rt equals id_rs or id_rt.
- During a stall, ID/EX loads a bubble (all 0, illegal_op=0). Exactly one stall cycle per load-use pair.
- id_jump = id_valid & Jump. When id_jump is 1, if_flush=1; ID/EX still loads the jump's decode (all 0).
- ex_branch_taken=1 causes all of the following:
  - if_flush=1;
  - ID/EX loads a bubble;
  - stall forced to 0, because flush outranks stall;
  - id_jump forced to 0.
- Priority on the ID/EX load: rst, then ex_branch_taken, then stall, then !id_valid (bubble), then decode.
- Register 0 as destination never triggers a hazard.
- Reset asserted mid-operation clears all three stages in the same instant; nothing already in flight retires.

Optional Feature:
- Macro STALL_COUNT_EN.
  - Defined: stall_count port exists. It increments on each clock with stall=1, saturates at all-ones, and clears on rst.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW);
  - AluOp encodings;
  - a packed struct typedef ctrl_t for the decoded fields.
- One sub-module, ctrl_decode: purely combinational, opcode in, ctrl_t plus illegal out.
- Hazard logic, flush logic and stage registers stay in ctrl_pipeline.

Test Plan:
- Reset asserted mid-stream with lw in MEM → every output 0 immediately; stays 0 one cycle after release while id_valid=0.
- R-type (op 0) then sw (op 43), id_valid=1 → ex_reg_dst=1 with ex_alu_op=010 at cycle+1; mem_write=1 at cycle+2; wb_reg_write=1 from the R-type at cycle+3.
- lw with rt=5, then add with rs=5 → stall=1 for exactly one cycle; EX bubble (ex_alu_op=000, RegWrite=0 downstream); add reaches EX the next cycle.
- lw with rt=0, then add with rs=0 → stall stays 0.
- Hazard cycle with ex_branch_taken=1 → stall=0, if_flush=1, ID/EX all 0.
- Op 0x3F → illegal_op=1 at cycle+1, all other fields 0; op 2 → id_jump=1 and if_flush=1 in the same cycle.
- With STALL_COUNT_EN and CNT_W=2 → five load-use stalls give stall_count = 0,1,2,3,3.
